// File: rtl/hpi_bus_pkg.sv
// hpi_bus_pkg: shared definitions for the CY7C67200 HPI bus sequencer.
//   - engine FSM state encoding
//   - HPI register select codes driven on otg_addr
//   - Avalon register offsets and CTRL bit positions
package hpi_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_GAP    = 3'd4
  } cyc_state_t;

  localparam logic [1:0] HPI_DATA    = 2'b00;
  localparam logic [1:0] HPI_MAILBOX = 2'b01;
  localparam logic [1:0] HPI_ADDRESS = 2'b10;
  localparam logic [1:0] HPI_STATUS  = 2'b11;

  localparam logic [1:0] REG_MEM_ADDR = 2'd0;
  localparam logic [1:0] REG_MEM_DATA = 2'd1;
  localparam logic [1:0] REG_CTRL     = 2'd2;
  localparam logic [1:0] REG_MAILBOX  = 2'd3;

  // CTRL write bits
  localparam int CTRL_GO      = 0;
  localparam int CTRL_ERR_CLR = 1;
  localparam int CTRL_RST     = 8;

endpackage

// File: rtl/hpi_cycle_engine.sv
// hpi_cycle_engine: runs one HPI bus cycle with programmable timing.
//   state | meaning
//   IDLE  | no cycle in progress, strobes and cs_n released
//   SETUP | cs_n low, otg_addr valid, data driven for writes
//   STROBE| rd_n or wr_n low; read data captured on the last cycle
//   HOLD  | strobes released, cs_n still low, data held for writes
//   GAP   | one idle cycle between the two phases of a memory op
// Ports:
//   start           launch a cycle from IDLE (parameters taken from cyc_*)
//   more            another phase follows this one (HOLD -> GAP)
//   cyc_write/addr/data  phase parameters, latched on SETUP entry
//   cs_n/rd_n/wr_n/data_oe/hpi_addr/data_out  HPI bus drive
//   capture         read data valid on otg_data_in this cycle
//   done            last HOLD cycle of the final phase
//   in_gap          engine sits in GAP (next phase loads on exit)
module hpi_cycle_engine
  import hpi_bus_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        more,
  input  logic        cyc_write,
  input  logic [1:0]  cyc_addr,
  input  logic [15:0] cyc_data,
  output logic        cs_n,
  output logic        rd_n,
  output logic        wr_n,
  output logic        data_oe,
  output logic [1:0]  hpi_addr,
  output logic [15:0] data_out,
  output logic        capture,
  output logic        done,
  output logic        in_gap
);

  localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 1);

  cyc_state_t  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        load;
  logic        tc;
  logic        wr_q;
  logic [1:0]  addr_q;
  logic [15:0] data_q;

  assign tc = (cnt_q == 4'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 2'b00;
      data_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (load) begin
        wr_q   <= cyc_write;
        addr_q <= cyc_addr;
        data_q <= cyc_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = tc ? cnt_q : cnt_q - 4'd1;
    load    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = cnt_q;
        if (start) begin
          state_d = ST_SETUP;
          cnt_d   = SETUP_LOAD;
          load    = 1'b1;
        end
      end
      ST_SETUP:  if (tc) begin state_d = ST_STROBE; cnt_d = STROBE_LOAD; end
      ST_STROBE: if (tc) begin state_d = ST_HOLD;   cnt_d = HOLD_LOAD;   end
      ST_HOLD:   if (tc) state_d = more ? ST_GAP : ST_IDLE;
      ST_GAP: begin
        state_d = ST_SETUP;
        cnt_d   = SETUP_LOAD;
        load    = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Decoded straight from the state register so an async reset releases
  // the strobes without waiting for a clock edge.
  always_comb begin
    cs_n    = 1'b1;
    rd_n    = 1'b1;
    wr_n    = 1'b1;
    data_oe = 1'b0;
    capture = 1'b0;
    done    = 1'b0;
    in_gap  = 1'b0;
    case (state_q)
      ST_SETUP: begin
        cs_n    = 1'b0;
        data_oe = wr_q;
      end
      ST_STROBE: begin
        cs_n    = 1'b0;
        data_oe = wr_q;
        wr_n    = ~wr_q;
        rd_n    = wr_q;
        capture = ~wr_q & tc;
      end
      ST_HOLD: begin
        cs_n    = 1'b0;
        data_oe = wr_q;
        done    = tc & ~more;
      end
      ST_GAP:  in_gap = 1'b1;
      default: ;
    endcase
  end

  assign hpi_addr = addr_q;
  assign data_out = data_q;

endmodule

// File: rtl/hpi_bus_ctrl.sv
// hpi_bus_ctrl: Avalon-MM slave that sequences CY7C67200 HPI bus cycles.
//   Avalon side: clk, reset_n, address, chipselect, read_n, write_n,
//                writedata, readdata (registered, 1-cycle latency)
//   HPI side:    otg_data_in/out/oe, otg_addr, otg_cs_n, otg_rd_n,
//                otg_wr_n, otg_rst_n
// Registers: 0 MEM_ADDR, 1 MEM_DATA (write launches memory write, read
// returns captured data), 2 CTRL {RST@8, ERR@1, BUSY@0}, 3 MAILBOX.
// Optional macro HPI_ADDR_SKIP_EN: remember the chip's auto-incremented
// address and skip the ADDRESS phase when the next op targets it.
module hpi_bus_ctrl
  import hpi_bus_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 4,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [15:0] otg_data_in,
  output logic [15:0] otg_data_out,
  output logic        otg_data_oe,
  output logic [1:0]  otg_addr,
  output logic        otg_cs_n,
  output logic        otg_rd_n,
  output logic        otg_wr_n,
  output logic        otg_rst_n
);

  logic [15:0] mem_addr, rdata, op_data;
  logic        err, busy, rst_bit, op_write, op_mem, pending;
  logic        wr_en, rd_en, ctrl_wr;
  logic        launch_mw, launch_mr, launch_mb, launch, accept, drop;
  logic        skip;
  logic        cyc_write;
  logic [1:0]  cyc_addr;
  logic [15:0] cyc_data;
  logic        capture, done, in_gap;
  logic        unused_bits;

  assign wr_en     = chipselect & ~write_n;
  assign rd_en     = chipselect & ~read_n;
  assign ctrl_wr   = wr_en & (address == REG_CTRL);
  assign launch_mw = wr_en & (address == REG_MEM_DATA);
  assign launch_mr = ctrl_wr & writedata[CTRL_GO];
  assign launch_mb = wr_en & (address == REG_MAILBOX);
  assign launch    = launch_mw | launch_mr | launch_mb;
  assign accept    = launch & ~busy;
  assign drop      = launch & busy;
  assign unused_bits = ^{writedata[31:16], writedata[15:9], writedata[7:2]};

`ifdef HPI_ADDR_SKIP_EN
  logic [15:0] op_addr, shadow;
  logic        shadow_valid;

  assign skip = shadow_valid & (mem_addr == shadow);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_addr      <= 16'h0000;
      shadow       <= 16'h0000;
      shadow_valid <= 1'b0;
    end else begin
      if (accept) op_addr <= mem_addr;
      if (done && op_mem) begin
        shadow       <= op_addr + 16'd2;
        shadow_valid <= 1'b1;
      end
      if ((accept && launch_mb) || rst_bit) shadow_valid <= 1'b0;
    end
  end
`else
  assign skip = 1'b0;
`endif

  // In GAP the engine loads the DATA phase of the op in flight; from IDLE
  // it loads the first phase of the command being accepted.
  always_comb begin
    cyc_write = 1'b1;
    cyc_addr  = HPI_ADDRESS;
    cyc_data  = mem_addr;
    if (in_gap) begin
      cyc_write = op_write;
      cyc_addr  = HPI_DATA;
      cyc_data  = op_data;
    end else if (launch_mb) begin
      cyc_addr = HPI_MAILBOX;
      cyc_data = writedata[15:0];
    end else if (skip) begin
      cyc_write = launch_mw;
      cyc_addr  = HPI_DATA;
      cyc_data  = writedata[15:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr  <= 16'h0000;
      rdata     <= 16'h0000;
      err       <= 1'b0;
      busy      <= 1'b0;
      rst_bit   <= 1'b1;
      otg_rst_n <= 1'b0;
      op_data   <= 16'h0000;
      op_write  <= 1'b0;
      op_mem    <= 1'b0;
      pending   <= 1'b0;
      readdata  <= 32'h0;
    end else begin
      if (wr_en && address == REG_MEM_ADDR) mem_addr <= writedata[15:0];
      if (ctrl_wr) begin
        rst_bit   <= writedata[CTRL_RST];
        otg_rst_n <= ~writedata[CTRL_RST];
        if (writedata[CTRL_ERR_CLR]) err <= 1'b0;
      end
      // Set after the clear so a clear+launch while busy leaves ERR set.
      if (drop) err <= 1'b1;
      if (accept) begin
        busy     <= 1'b1;
        op_data  <= writedata[15:0];
        op_write <= launch_mw;
        op_mem   <= ~launch_mb;
        pending  <= ~launch_mb & ~skip;
      end
      if (in_gap) pending <= 1'b0;
      if (done) busy <= 1'b0;
      if (capture) rdata <= otg_data_in;
      if (rd_en) begin
        case (address)
          REG_MEM_ADDR: readdata <= {16'h0000, mem_addr};
          REG_MEM_DATA: readdata <= {16'h0000, rdata};
          REG_CTRL:     readdata <= {23'd0, rst_bit, 6'd0, err, busy};
          default:      readdata <= 32'h0;
        endcase
      end
    end
  end

  hpi_cycle_engine #(
    .SETUP_CYCLES  (SETUP_CYCLES),
    .STROBE_CYCLES (STROBE_CYCLES),
    .HOLD_CYCLES   (HOLD_CYCLES)
  ) u_engine (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (accept),
    .more      (pending),
    .cyc_write (cyc_write),
    .cyc_addr  (cyc_addr),
    .cyc_data  (cyc_data),
    .cs_n      (otg_cs_n),
    .rd_n      (otg_rd_n),
    .wr_n      (otg_wr_n),
    .data_oe   (otg_data_oe),
    .hpi_addr  (otg_addr),
    .data_out  (otg_data_out),
    .capture   (capture),
    .done      (done),
    .in_gap    (in_gap)
  );

endmodule
